// File: rtl/move_controller.sv
// Reversi/Othello move engine: validates a move on an 8x8 board, walks all
// eight directions one cell per cycle, flips captured discs one cell per
// cycle and presents the resulting board with a legal flag and flip count.
module move_controller (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   row,
  input  logic [2:0]   col,
  input  logic         player_black,
  input  logic [191:0] board_in,
  output logic         busy,
  output logic         done,
  output logic         legal,
  output logic [5:0]   flip_count,
  output logic [191:0] board_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN,
    S_FLIP,
    S_FINISH,
    S_DONE
  } state_t;

  state_t state, state_next;

  // Working copy of the move: board, target square and mover colour.
  logic [191:0] work_board;
  logic [2:0]   tgt_row, tgt_col;
  logic         mover_black;

  // Direction walker. Coordinates are signed so stepping off either edge
  // (to -1 or 8) is visible on each axis independently; no index wrap.
  logic [2:0]        dir;
  logic signed [4:0] walk_row, walk_col;
  logic [2:0]        run;        // opponent discs seen in current direction
  logic [2:0]        flip_left;  // cells still to rewrite in FLIP

  // Row delta for direction d: N, NE, E, SE, S, SW, W, NW.
  function automatic logic signed [4:0] step_row(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: step_row = -5'sd1;
      3'd3, 3'd4, 3'd5: step_row = 5'sd1;
      default:          step_row = 5'sd0;
    endcase
  endfunction

  // Column delta for direction d.
  function automatic logic signed [4:0] step_col(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: step_col = 5'sd1;
      3'd5, 3'd6, 3'd7: step_col = -5'sd1;
      default:          step_col = 5'sd0;
    endcase
  endfunction

  logic signed [4:0] tgt_row_s, tgt_col_s;
  logic [2:0]        mover_code;
  logic [7:0]        walk_bit, tgt_bit;
  logic              walk_on_board, walk_occ, walk_blk, tgt_occ;
  logic              walk_own, walk_opp;
  logic [2:0]        dir_inc;

  assign tgt_row_s  = signed'({2'b00, tgt_row});
  assign tgt_col_s  = signed'({2'b00, tgt_col});
  assign mover_code = mover_black ? 3'b111 : 3'b110;
  assign dir_inc    = dir + 3'd1;

  // A coordinate lies in 0..7 exactly when its two top bits are clear.
  assign walk_on_board = (walk_row[4:3] == 2'b00) && (walk_col[4:3] == 2'b00);

  // Bit offsets of the walker cell and the target cell (index * 3).
  assign walk_bit = {2'b00, walk_row[2:0], walk_col[2:0]} * 8'd3;
  assign tgt_bit  = {2'b00, tgt_row, tgt_col} * 8'd3;

  assign walk_occ = work_board[walk_bit + 8'd2];
  assign walk_blk = work_board[walk_bit];
  assign tgt_occ  = work_board[tgt_bit + 8'd2];

  assign walk_own = walk_occ && (walk_blk == mover_black);
  assign walk_opp = walk_occ && (walk_blk != mover_black);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Decision signals shared by the FSM and the datapath.
  logic advance_dir;  // current direction finished, move to the next one

  // Next-state logic for the move sequencer.
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_next  = state;
    advance_dir = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_next = S_CHECK;
      S_CHECK:  state_next = tgt_occ ? S_FINISH : S_SCAN;
      S_SCAN: begin
        if (!walk_on_board || !walk_occ) begin
          advance_dir = 1'b1;
        end else if (walk_own) begin
          if (run != 3'd0) state_next = S_FLIP;
          else             advance_dir = 1'b1;
        end
      end
      S_FLIP:   if (flip_left == 3'd1) advance_dir = 1'b1;
      S_FINISH: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (advance_dir) state_next = (dir == 3'd7) ? S_FINISH : S_SCAN;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample values from the same edge regardless of block order.
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Working registers, walker and result outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the 192-bit working board is a plain register bank, not a RAM,
      // so it is cleared on reset like every other working register.
      work_board  <= '0;
      tgt_row     <= '0;
      tgt_col     <= '0;
      mover_black <= 1'b0;
      dir         <= '0;
      walk_row    <= '0;
      walk_col    <= '0;
      run         <= '0;
      flip_left   <= '0;
      legal       <= 1'b0;
      flip_count  <= '0;
      board_out   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            work_board  <= board_in;
            tgt_row     <= row;
            tgt_col     <= col;
            mover_black <= player_black;
            flip_count  <= '0;
            legal       <= 1'b0;
          end
        end
        S_CHECK: begin
          dir      <= 3'd0;
          walk_row <= tgt_row_s + step_row(3'd0);
          walk_col <= tgt_col_s + step_col(3'd0);
          run      <= '0;
        end
        S_SCAN: begin
          if (advance_dir) begin
            dir      <= dir_inc;
            walk_row <= tgt_row_s + step_row(dir_inc);
            walk_col <= tgt_col_s + step_col(dir_inc);
            run      <= '0;
          end else if (walk_own) begin
            // Capped run: rewind to the first cell after the target.
            walk_row  <= tgt_row_s + step_row(dir);
            walk_col  <= tgt_col_s + step_col(dir);
            flip_left <= run;
          end else if (walk_opp) begin
            run      <= run + 3'd1;
            walk_row <= walk_row + step_row(dir);
            walk_col <= walk_col + step_col(dir);
          end
        end
        S_FLIP: begin
          work_board[walk_bit +: 3] <= mover_code;
          walk_row  <= walk_row + step_row(dir);
          walk_col  <= walk_col + step_col(dir);
          flip_left <= flip_left - 3'd1;
          if (advance_dir) begin
            flip_count <= flip_count + {3'b000, run};
            dir        <= dir_inc;
            walk_row   <= tgt_row_s + step_row(dir_inc);
            walk_col   <= tgt_col_s + step_col(dir_inc);
            run        <= '0;
          end
        end
        S_FINISH: begin
          // The working board is only modified by FLIP, which always adds to
          // flip_count; with zero flips it still equals the latched board.
          board_out <= work_board;
          if (flip_count != 6'd0) begin
            work_board[tgt_bit +: 3] <= mover_code;
            board_out[tgt_bit +: 3]  <= mover_code;
            legal                    <= 1'b1;
          end else begin
            legal <= 1'b0;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed self-checking bench for move_controller.
module tb_move_controller;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [2:0]   row, col;
  logic         player_black;
  logic [191:0] board_in;
  logic         busy, done, legal;
  logic [5:0]   flip_count;
  logic [191:0] board_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] BLK = 3'b111;
  localparam logic [2:0] WHT = 3'b110;

  move_controller dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .row          (row),
    .col          (col),
    .player_black (player_black),
    .board_in     (board_in),
    .busy         (busy),
    .done         (done),
    .legal        (legal),
    .flip_count   (flip_count),
    .board_out    (board_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [191:0] put(input logic [191:0] b, input int idx, input logic [2:0] v);
    logic [191:0] r;
    r = b;
    r[3*idx +: 3] = v;
    return r;
  endfunction

  // Launch one move and wait for done. lat counts cycles after the accept
  // edge (CHECK = 1). At cycle pulse_at a stray start with junk inputs is
  // driven; it must be ignored.
  task automatic run_move(input logic [2:0] r, input logic [2:0] c, input logic p,
                          input logic [191:0] b, input int pulse_at,
                          output int lat, output logic busy_at_done);
    @(negedge clk);
    row = r; col = c; player_black = p; board_in = b; start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin
        start = 1'b1; row = 3'd0; col = 3'd0; player_black = ~p; board_in = '0;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 200);
    busy_at_done = busy;
  endtask

  // done must be a single pulse, busy must drop, and nothing may be queued.
  task automatic check_after(input string tag, input logic [191:0] exp_board);
    @(negedge clk);
    check({tag, "_done_low"}, {191'b0, done}, 192'd0);
    check({tag, "_busy_low"}, {191'b0, busy}, 192'd0);
    @(negedge clk);
    check({tag, "_no_queue"}, {191'b0, busy}, 192'd0);
    check({tag, "_held"}, board_out, exp_board);
  endtask

  logic [191:0] opening, exp_b, b_wrap, b_multi;
  int           lat;
  logic         bad;

  initial begin
    resetn = 1'b0; start = 1'b1; row = 3'd2; col = 3'd3;
    player_black = 1'b1; board_in = '1;

    opening = '0;
    opening = put(opening, 27, WHT);
    opening = put(opening, 36, WHT);
    opening = put(opening, 28, BLK);
    opening = put(opening, 35, BLK);

    // Reset with start held high: nothing accepted, all outputs zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {191'b0, busy},  192'd0);
    check("rst_done",  {191'b0, done},  192'd0);
    check("rst_legal", {191'b0, legal}, 192'd0);
    check("rst_flips", {186'b0, flip_count}, 192'd0);
    check("rst_board", board_out, 192'd0);
    start = 1'b0;
    resetn = 1'b1;

    // Opening board, black at (2,3): captures 27 southward.
    exp_b = put(put(opening, 19, BLK), 27, BLK);
    run_move(3'd2, 3'd3, 1'b1, opening, 0, lat, bad);
    check("open_done",  {191'b0, done},  192'd1);
    check("open_busy",  {191'b0, bad},   192'd1);
    check("open_lat_ok", {191'b0, lat <= 76}, 192'd1);
    check("open_legal", {191'b0, legal}, 192'd1);
    check("open_flips", {186'b0, flip_count}, 192'd1);
    check("open_board", board_out, exp_b);
    check_after("open", exp_b);

    // Opening board, white at (2,4): captures 28 southward.
    exp_b = put(put(opening, 20, WHT), 28, WHT);
    run_move(3'd2, 3'd4, 1'b0, opening, 0, lat, bad);
    check("white_legal", {191'b0, legal}, 192'd1);
    check("white_flips", {186'b0, flip_count}, 192'd1);
    check("white_board", board_out, exp_b);

    // Occupied target: CHECK, FINISH, DONE.
    run_move(3'd3, 3'd3, 1'b1, opening, 0, lat, bad);
    check("occ_latency", 192'(lat), 192'd3);
    check("occ_legal",   {191'b0, legal}, 192'd0);
    check("occ_flips",   {186'b0, flip_count}, 192'd0);
    check("occ_board",   board_out, opening);
    check_after("occ", opening);

    // Corner with no neighbours.
    run_move(3'd0, 3'd0, 1'b1, opening, 0, lat, bad);
    check("corner_legal", {191'b0, legal}, 192'd0);
    check("corner_flips", {186'b0, flip_count}, 192'd0);
    check("corner_board", board_out, opening);

    // Row-boundary wrap must not capture: 24 white, 25 black, black at (2,7).
    b_wrap = put(put(192'd0, 24, WHT), 25, BLK);
    run_move(3'd2, 3'd7, 1'b1, b_wrap, 0, lat, bad);
    check("wrap_done",  {191'b0, done},  192'd1);
    check("wrap_legal", {191'b0, legal}, 192'd0);
    check("wrap_flips", {186'b0, flip_count}, 192'd0);
    check("wrap_board", board_out, b_wrap);

    // Multi-direction at (4,4), black: N run 2 (28,20 cap 12), E run 1
    // (37 cap 38), SW run 2 (43,50 cap 57); W open-ended (35,34), S own.
    b_multi = '0;
    b_multi = put(b_multi, 28, WHT); b_multi = put(b_multi, 20, WHT);
    b_multi = put(b_multi, 12, BLK);
    b_multi = put(b_multi, 37, WHT); b_multi = put(b_multi, 38, BLK);
    b_multi = put(b_multi, 43, WHT); b_multi = put(b_multi, 50, WHT);
    b_multi = put(b_multi, 57, BLK);
    b_multi = put(b_multi, 35, WHT); b_multi = put(b_multi, 34, WHT);
    b_multi = put(b_multi, 44, BLK);
    exp_b = b_multi;
    exp_b = put(exp_b, 36, BLK); exp_b = put(exp_b, 28, BLK);
    exp_b = put(exp_b, 20, BLK); exp_b = put(exp_b, 37, BLK);
    exp_b = put(exp_b, 43, BLK); exp_b = put(exp_b, 50, BLK);
    run_move(3'd4, 3'd4, 1'b1, b_multi, 0, lat, bad);
    check("multi_legal", {191'b0, legal}, 192'd1);
    check("multi_flips", {186'b0, flip_count}, 192'd5);
    check("multi_board", board_out, exp_b);

    // Same move with a stray start (junk inputs) pulsed mid-SCAN.
    run_move(3'd4, 3'd4, 1'b1, b_multi, 4, lat, bad);
    check("pulse_legal", {191'b0, legal}, 192'd1);
    check("pulse_flips", {186'b0, flip_count}, 192'd5);
    check("pulse_board", board_out, exp_b);
    check_after("pulse", exp_b);

    // Reset while flipping: opening move (2,3) is in FLIP at cycle 8.
    @(negedge clk);
    row = 3'd2; col = 3'd3; player_black = 1'b1; board_in = opening; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_busy",  {191'b0, busy},  192'd0);
    check("midrst_done",  {191'b0, done},  192'd0);
    check("midrst_legal", {191'b0, legal}, 192'd0);
    check("midrst_flips", {186'b0, flip_count}, 192'd0);
    check("midrst_board", board_out, 192'd0);
    resetn = 1'b1;

    // A fresh start after the abort is accepted and completes correctly.
    exp_b = put(put(opening, 19, BLK), 27, BLK);
    run_move(3'd2, 3'd3, 1'b1, opening, 0, lat, bad);
    check("rerun_done",  {191'b0, done},  192'd1);
    check("rerun_legal", {191'b0, legal}, 192'd1);
    check("rerun_flips", {186'b0, flip_count}, 192'd1);
    check("rerun_board", board_out, exp_b);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
